nmi_timeout_bridge: RTL and testbench

- Sits directly downstream of a user core's NMI master port, between that port and the SoC NMI crossbar.
- Registers each request (addr/wdata/wstrb) and forwards it to the fabric.
- If the fabric does not answer within TIMEOUT_CYCLES, it completes the core's transaction with a fixed error read value and logs the fault, so a hung slave cannot lock the core.
- Exposes sticky error status for a system register block.

---
 rtl/nmi_bridge_pkg.sv | 8 +
 rtl/nmi_wait_timer.sv | 20 ++
 rtl/nmi_timeout_bridge.sv | 77 +++++++
 tb/tb_nmi_timeout_bridge.sv | 139 +++++++++++++
 4 files changed

// File: rtl/nmi_bridge_pkg.sv
// nmi_bridge_pkg: shared state encoding, NMI field widths and error read value
package nmi_bridge_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
endpackage

// File: rtl/nmi_wait_timer.sv
// nmi_wait_timer: counts stalled request cycles and pulses when the limit is reached
module nmi_wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  logic [W-1:0] cnt_q;
  // stall counter, held at zero outside of a pending request
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && TIMEOUT_CYCLES != 0) cnt_q <= cnt_q + W'(1);
  assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LAST);
endmodule

// File: rtl/nmi_timeout_bridge.sv
// nmi_timeout_bridge: registers core NMI requests and completes them with an error if the fabric hangs
module nmi_timeout_bridge
  import nmi_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [ADDR_W-1:0]    s_addr_i,
  input  logic [DATA_W-1:0]    s_wdata_i,
  input  logic [STRB_W-1:0]    s_wstrb_i,
  output logic [DATA_W-1:0]    s_rdata_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [ADDR_W-1:0]    m_addr_o,
  output logic [DATA_W-1:0]    m_wdata_o,
  output logic [STRB_W-1:0]    m_wstrb_o,
  input  logic [DATA_W-1:0]    m_rdata_i,
  input  logic                 err_clr_i,
  output logic                 err_o,
  output logic [ADDR_W-1:0]    err_addr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  state_t state_q, state_d;
  logic expired;
  nmi_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (state_q != REQ),
    .en_i     (state_q == REQ && !m_ready_i),
    .expired_o(expired)
  );
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state_q <= IDLE;
    else state_q <= state_d;
  // next state and handshake outputs; fabric ready beats a coincident timeout
  always_comb begin
    state_d   = state_q;
    s_ready_o = state_q == RESP;
    m_valid_o = state_q == REQ;
    state_d   = state_q == IDLE ? (s_valid_i ? REQ : IDLE) :
                state_q == REQ  ? ((m_ready_i || expired) ? RESP : REQ) : IDLE;
  end
  // request capture, response data and sticky error log; a timeout outranks a clear
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      m_addr_o   <= '0;
      m_wdata_o  <= '0;
      m_wstrb_o  <= '0;
      s_rdata_o  <= '0;
      err_o      <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      if (state_q == IDLE && s_valid_i) begin
        m_addr_o  <= s_addr_i;
        m_wdata_o <= s_wdata_i;
        m_wstrb_o <= s_wstrb_i;
      end
      if (state_q == REQ && m_ready_i) s_rdata_o <= m_rdata_i;
      else if (expired) s_rdata_o <= ERR_RDATA;
      if (expired) begin
        err_o      <= 1'b1;
        err_addr_o <= m_addr_o;
        err_cnt_o  <= err_clr_i ? ERR_CNT_W'(1) : (&err_cnt_o ? err_cnt_o : err_cnt_o + ERR_CNT_W'(1));
      end else if (err_clr_i) begin
        err_o      <= 1'b0;
        err_addr_o <= '0;
        err_cnt_o  <= '0;
      end
    end
endmodule

// File: tb/tb_nmi_timeout_bridge.sv
// tb_nmi_timeout_bridge: scoreboard bench for the NMI timeout bridge
module tb_nmi_timeout_bridge;
  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, err_clr = 1'b0, err;
  logic [31:0] s_addr = '0, s_wdata = '0, s_rdata, m_addr, m_wdata, m_rdata = '0, err_addr;
  logic [3:0] s_wstrb = '0, m_wstrb;
  logic [7:0] err_cnt;
  int n_cmp = 0, n_err = 0;
  typedef struct {logic [31:0] rdata; logic err; logic [7:0] cnt; logic [31:0] eaddr;} exp_t;
  exp_t sb[$];
  logic exp_err = 1'b0;
  logic [7:0] exp_cnt = '0;
  logic [31:0] exp_eaddr = '0;

  nmi_timeout_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_addr_i(s_addr), .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_rdata_o(s_rdata),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_wstrb_o(m_wstrb), .m_rdata_i(m_rdata), .err_clr_i(err_clr), .err_o(err),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && s_ready) begin
      if (sb.size() == 0) check("spurious_s_ready", 32'(s_ready), 32'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        check("s_rdata", s_rdata, e.rdata);
        check("err_o", 32'(err), 32'(e.err));
        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
        check("err_addr", err_addr, e.eaddr);
      end
    end

  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int dly, input logic [31:0] rdata, input int clr_at, input bit full);
    bit to;
    int cyc = 0;
    to = (dly < 0 || dly >= TO);
    if (to) begin
      exp_err = 1'b1;
      exp_eaddr = addr;
      exp_cnt = (clr_at == TO - 1) ? 8'd1 : (exp_cnt == 8'hFF ? 8'hFF : exp_cnt + 8'd1);
    end else if (clr_at >= 0 && clr_at <= dly) begin
      exp_err = 1'b0;
      exp_eaddr = '0;
      exp_cnt = '0;
    end
    sb.push_back('{to ? ERR : rdata, exp_err, exp_cnt, exp_eaddr});
    s_valid = 1'b1; s_addr = addr; s_wdata = wdata; s_wstrb = wstrb;
    @(posedge clk); #1;
    s_valid = 1'b0; s_addr = $urandom; s_wdata = $urandom; s_wstrb = 4'hF;
    while (m_valid && cyc < 100) begin
      if (full && cyc == 0) begin
        check("m_addr", m_addr, addr);
        check("m_wdata", m_wdata, wdata);
        check("m_wstrb", 32'(m_wstrb), 32'(wstrb));
      end
      m_ready = (cyc == dly);
      m_rdata = (cyc == dly) ? rdata : 32'h0BAD_F00D;
      err_clr = (cyc == clr_at);
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0; err_clr = 1'b0;
    if (full) check("m_valid_len", 32'(cyc), 32'(to ? TO : dly + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    // 1: read, ready on the third REQ cycle
    do_req(32'h1000_0004, 32'h0, 4'b0000, 2, 32'h1234_5678, -1, 1);
    // 2: write, ready immediately (3-cycle round trip)
    do_req(32'h3000_0010, 32'hA5A5_A5A5, 4'b0011, 0, 32'h5555_0000, -1, 1);
    // 3: timeout, then a late ready in IDLE is ignored
    do_req(32'h4000_0020, 32'h0, 4'b0000, -1, 32'h0, -1, 1);
    m_ready = 1'b1; m_rdata = 32'h0BAD_0BAD;
    repeat (3) @(posedge clk);
    #1;
    check("late_ready_rdata", s_rdata, ERR);
    check("late_ready_m_valid", 32'(m_valid), 0);
    m_ready = 1'b0;
    // 4: ready coincident with the timeout cycle wins
    do_req(32'h5000_0030, 32'h0, 4'b0000, TO - 1, 32'hCAFE_0001, -1, 1);
    // 5: clear, saturation, clear racing a timeout
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    exp_err = 1'b0; exp_cnt = '0; exp_eaddr = '0;
    check("clr_err", 32'(err), 0);
    check("clr_cnt", 32'(err_cnt), 0);
    for (int i = 0; i < 256; i++) do_req(32'h6000_0000 + 32'(i), 32'h0, 4'b0000, -1, 32'h0, -1, 0);
    check("sat_cnt", 32'(err_cnt), 32'hFF);
    do_req(32'h7000_0040, 32'h0, 4'b0000, -1, 32'h0, TO - 1, 1);
    check("clr_vs_to_cnt", 32'(err_cnt), 1);
    check("clr_vs_to_err", 32'(err), 1);
    // 6: asynchronous reset in REQ
    s_valid = 1'b1; s_addr = 32'h8000_0050; s_wstrb = 4'hF;
    @(posedge clk); #1; s_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(m_valid), 0);
    check("arst_s_ready", 32'(s_ready), 0);
    check("arst_m_addr", m_addr, 0);
    check("arst_m_wstrb", 32'(m_wstrb), 0);
    check("arst_s_rdata", s_rdata, 0);
    check("arst_err", 32'(err), 0);
    check("arst_err_addr", err_addr, 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    exp_err = 1'b0; exp_cnt = '0; exp_eaddr = '0;
    @(posedge clk); #3; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_req(32'h9000_0060, 32'h0, 4'b0000, 1, 32'h600D_600D, -1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
